// File: rtl/tile_skew_feeder.sv
// tile_skew_feeder: drains SIZE x SIZE tiles from the tile FIFO and streams them into the
// systolic array as a diagonal wavefront, lane i carrying column i delayed by i beats.
module tile_skew_feeder #(
  parameter int BITS = 8,
  parameter int SIZE = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            fifo_pop,
  input  logic            fifo_pop_rdy,
  input  logic [BITS-1:0] fifo_dout [SIZE][SIZE],
  output logic            out_valid,
  input  logic            out_rdy,
  output logic [BITS-1:0] lane_data [SIZE],
  output logic [SIZE-1:0] lane_valid,
  output logic            tile_done,
  output logic            busy
);
  localparam int SW = $clog2(2*SIZE);
  localparam int RW = $clog2(SIZE);
  localparam logic [SW-1:0] LAST = SW'(2*SIZE-2);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
  state_t          state;
  logic [SW-1:0]   step;
  logic [BITS-1:0] tile_q [SIZE][SIZE];
  logic            last;
  assign last      = state == STREAM && step == LAST;
  assign fifo_pop  = !rst && fifo_pop_rdy && (state == IDLE || (last && out_rdy));
  assign out_valid = state == STREAM;
  assign tile_done = last && out_rdy;
  assign busy      = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      step   <= '0;
      tile_q <= '{default: '0};
    end else if (state == IDLE) begin
      if (fifo_pop) state <= LOAD;
    end else if (state == LOAD) begin
      tile_q <= fifo_dout;
      step   <= '0;
      state  <= STREAM;
    end else if (out_rdy) begin
      step <= last ? '0 : step + 1'b1;
      if (last) state <= fifo_pop ? LOAD : IDLE;
    end
  end
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [SW-1:0] r;
    // step >= i guards the unsigned subtraction, equivalent to 0 <= step-i
    assign r             = step - SW'(i);
    assign lane_valid[i] = out_valid && step >= SW'(i) && r < SW'(SIZE);
    assign lane_data[i]  = lane_valid[i] ? tile_q[r[RW-1:0]][i] : '0;
  end
endmodule
